// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller and instruction register for the JTAG-to-AXI bridge.
// Define JTAG_IR_READBACK_EN to capture the active instruction in CAPTURE_IR.

package jtag_tap_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET,
        RUN_TEST_IDLE,
        SELECT_DR_SCAN,
        CAPTURE_DR,
        SHIFT_DR,
        EXIT1_DR,
        PAUSE_DR,
        EXIT2_DR,
        UPDATE_DR,
        SELECT_IR_SCAN,
        CAPTURE_IR,
        SHIFT_IR,
        EXIT1_IR,
        PAUSE_IR,
        EXIT2_IR,
        UPDATE_IR
    } tap_ctrl_fsm_t;

    typedef enum logic [2:0] {
        IDCODE,
        ADDR_REGISTER,
        DATA_WR_REGISTER,
        DATA_RD_REGISTER,
        BYPASS
    } ir_decoding_t;

endpackage

module jtag_tap_ctrl
    import jtag_tap_pkg::*;
#(
    parameter int                  IR_WIDTH   = 4,
    parameter logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'('h1),
    parameter logic [IR_WIDTH-1:0] IR_ADDR    = IR_WIDTH'('h2),
    parameter logic [IR_WIDTH-1:0] IR_DATA_WR = IR_WIDTH'('h3),
    parameter logic [IR_WIDTH-1:0] IR_DATA_RD = IR_WIDTH'('h4),
    parameter logic [IR_WIDTH-1:0] IR_BYPASS  = '1
) (
    input  logic                tck,
    input  logic                trstn,
    input  logic                tms,
    input  logic                tdi,
    input  logic                dr_tdo,
    output logic                tdo,
    output logic                tdo_oe,
    output tap_ctrl_fsm_t       tap_state,
    output ir_decoding_t        ir_dec,
    output logic [IR_WIDTH-1:0] ir_value
);

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    tap_ctrl_fsm_t       state_q;
    tap_ctrl_fsm_t       state_d;
    logic [IR_WIDTH-1:0] ir_sr;
    logic                tdo_d;
    logic                tdo_oe_d;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the always blocks are evaluated.
    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // state_d unassigned, which would infer a latch.
        state_d = state_q;
        unique case (state_q)
            TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   state_d = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    always_comb begin
        tdo_d    = 1'b0;
        tdo_oe_d = 1'b0;
        if (state_q == SHIFT_IR) begin
            tdo_d    = ir_sr[0];
            tdo_oe_d = 1'b1;
        end else if (state_q == SHIFT_DR) begin
            tdo_d    = dr_tdo;
            tdo_oe_d = 1'b1;
        end
    end

    assign tap_state = state_q;

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            ir_sr <= '0;
        end else if (state_q == CAPTURE_IR) begin
`ifdef JTAG_IR_READBACK_EN
            ir_sr <= ir_value;
`else
            ir_sr <= IR_CAPTURE;
`endif
        end else if (state_q == SHIFT_IR) begin
            ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
        end
    end

    // Update and TDO launch on the falling edge so they are settled half a
    // cycle before the next rising edge seen by the DR block and the host.
    always_ff @(negedge tck or negedge trstn) begin
        if (!trstn) begin
            ir_value <= IR_IDCODE;
        end else if (state_q == TEST_LOGIC_RESET) begin
            ir_value <= IR_IDCODE;
        end else if (state_q == UPDATE_IR) begin
            ir_value <= ir_sr;
        end
    end

    always_ff @(negedge tck or negedge trstn) begin
        if (!trstn) begin
            tdo    <= 1'b0;
            tdo_oe <= 1'b0;
        end else begin
            tdo    <= tdo_d;
            tdo_oe <= tdo_oe_d;
        end
    end

    always_comb begin
        if (ir_value == IR_IDCODE) begin
            ir_dec = IDCODE;
        end else if (ir_value == IR_ADDR) begin
            ir_dec = ADDR_REGISTER;
        end else if (ir_value == IR_DATA_WR) begin
            ir_dec = DATA_WR_REGISTER;
        end else if (ir_value == IR_DATA_RD) begin
            ir_dec = DATA_RD_REGISTER;
        end else begin
            ir_dec = BYPASS;
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed self-checking bench for jtag_tap_ctrl: reset, IR scans, DR scan,
// TLR via TMS and asynchronous abort of an IR scan.
module tb_jtag_tap_ctrl;
    import jtag_tap_pkg::*;

    logic          tck;
    logic          trstn;
    logic          tms;
    logic          tdi;
    logic          dr_tdo;
    logic          tdo;
    logic          tdo_oe;
    tap_ctrl_fsm_t tap_state;
    ir_decoding_t  ir_dec;
    logic [3:0]    ir_value;

    int total = 0;
    int bad   = 0;

`ifdef JTAG_IR_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic [3:0] exp_ir;

    jtag_tap_ctrl #(.IR_WIDTH(4)) dut (
        .tck       (tck),
        .trstn     (trstn),
        .tms       (tms),
        .tdi       (tdi),
        .dr_tdo    (dr_tdo),
        .tdo       (tdo),
        .tdo_oe    (tdo_oe),
        .tap_state (tap_state),
        .ir_dec    (ir_dec),
        .ir_value  (ir_value)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One TCK: drive, let the rising and falling edges pass, sample just after.
    task automatic step(input logic tms_v, input logic tdi_v);
        tms = tms_v;
        tdi = tdi_v;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    // Full IR scan from RUN_TEST_IDLE back to RUN_TEST_IDLE.
    task automatic ir_scan(input logic [3:0] val, input logic [31:0] dec_exp);
        logic [3:0] cap;
        cap = READBACK ? exp_ir : 4'h1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("ir_capture_state", tap_state, CAPTURE_IR);
        step(1'b0, 1'b0);
        check("ir_shift_oe", tdo_oe, 1'b1);
        check("ir_tdo_bit0", tdo, cap[0]);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, val[i]);
            if (i < 3) begin
                check($sformatf("ir_tdo_bit%0d", i + 1), tdo, cap[i+1]);
            end
        end
        check("ir_exit1_state", tap_state, EXIT1_IR);
        check("ir_exit1_oe", tdo_oe, 1'b0);
        check("ir_hold_before_update", ir_value, exp_ir);
        step(1'b1, 1'b0);
        check("ir_value_updated", ir_value, val);
        check("ir_dec_updated", ir_dec, dec_exp);
        step(1'b0, 1'b0);
        check("ir_back_to_idle", tap_state, RUN_TEST_IDLE);
        exp_ir = val;
    endtask

    initial begin
        trstn  = 1'b0;
        tms    = 1'b1;
        tdi    = 1'b0;
        dr_tdo = 1'b0;
        exp_ir = 4'h1;
        #12;
        check("rst_state", tap_state, TEST_LOGIC_RESET);
        check("rst_ir_value", ir_value, 4'h1);
        check("rst_ir_dec", ir_dec, IDCODE);
        check("rst_tdo", tdo, 1'b0);
        check("rst_tdo_oe", tdo_oe, 1'b0);
        @(negedge tck);
        #1;
        trstn = 1'b1;

        step(1'b1, 1'b0);
        check("tlr_hold", tap_state, TEST_LOGIC_RESET);
        step(1'b0, 1'b0);
        check("to_idle", tap_state, RUN_TEST_IDLE);

        // Load ADDR, then five TMS=1 must land in TLR and restore IDCODE.
        ir_scan(4'h2, ADDR_REGISTER);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("tms5_state", tap_state, TEST_LOGIC_RESET);
        check("tms5_ir_value", ir_value, 4'h1);
        check("tms5_ir_dec", ir_dec, IDCODE);
        exp_ir = 4'h1;
        step(1'b0, 1'b0);
        check("idle_again", tap_state, RUN_TEST_IDLE);

        ir_scan(4'h7, BYPASS);
        ir_scan(4'hF, BYPASS);
        ir_scan(4'h3, DATA_WR_REGISTER);
        ir_scan(4'h4, DATA_RD_REGISTER);
        ir_scan(4'h2, ADDR_REGISTER);

        // DR scan: TDO follows dr_tdo, paused for three TCKs in between.
        step(1'b1, 1'b0);
        check("dr_select", tap_state, SELECT_DR_SCAN);
        step(1'b0, 1'b0);
        check("dr_capture_oe", tdo_oe, 1'b0);
        dr_tdo = 1'b1;
        step(1'b0, 1'b0);
        check("dr_shift_state", tap_state, SHIFT_DR);
        check("dr_tdo_0", tdo, 1'b1);
        check("dr_oe_0", tdo_oe, 1'b1);
        dr_tdo = 1'b0;
        step(1'b0, 1'b0);
        check("dr_tdo_1", tdo, 1'b0);
        step(1'b1, 1'b0);
        check("dr_exit1_oe", tdo_oe, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        check("dr_pause_state", tap_state, PAUSE_DR);
        check("dr_pause_oe", tdo_oe, 1'b0);
        step(1'b1, 1'b0);
        check("dr_exit2_state", tap_state, EXIT2_DR);
        dr_tdo = 1'b1;
        step(1'b0, 1'b0);
        check("dr_resume_oe", tdo_oe, 1'b1);
        check("dr_tdo_2", tdo, 1'b1);
        step(1'b0, 1'b0);
        check("dr_tdo_3", tdo, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("dr_update_state", tap_state, UPDATE_DR);
        check("dr_ir_unchanged", ir_value, 4'h2);
        step(1'b0, 1'b0);
        dr_tdo = 1'b0;

        // Leave SHIFT_IR into PAUSE_IR without update: IR must hold.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        check("pause_ir_state", tap_state, PAUSE_IR);
        check("pause_ir_hold", ir_value, 4'h2);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("abort_pre_oe", tdo_oe, 1'b1);

        // Asynchronous reset mid-shift.
        tms   = 1'b1;
        trstn = 1'b0;
        #1;
        check("abort_state", tap_state, TEST_LOGIC_RESET);
        check("abort_ir_value", ir_value, 4'h1);
        check("abort_tdo", tdo, 1'b0);
        check("abort_tdo_oe", tdo_oe, 1'b0);
        @(negedge tck);
        #1;
        trstn = 1'b1;
        exp_ir = 4'h1;
        step(1'b0, 1'b0);
        check("post_abort_idle", tap_state, RUN_TEST_IDLE);
        ir_scan(4'h3, DATA_WR_REGISTER);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
